// File: rtl/match_score_if.sv
// Bundle between the light-chain/player-input logic and the match scorer.
// The player side drives presses and edge lights; the scorer returns scores, status and 7-seg digits.
interface match_score_if #(
  parameter int unsigned SCORE_W = 3
);
  logic               l_press;
  logic               r_press;
  logic               l_edge;
  logic               r_edge;
  logic               new_game;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               round_rst;
  logic               match_over;
  logic [1:0]         winner;
  logic [6:0]         hex_l;
  logic [6:0]         hex_r;

  modport master (
    output l_press, r_press, l_edge, r_edge, new_game,
    input  score_l, score_r, round_rst, match_over, winner, hex_l, hex_r
  );

  modport slave (
    input  l_press, r_press, l_edge, r_edge, new_game,
    output score_l, score_r, round_rst, match_over, winner, hex_l, hex_r
  );
endinterface

// File: rtl/match_score_fsm.sv
// Two-player tug-of-war scorer: PLAY -> POINT (timed round reset) -> PLAY, or OVER at WIN_SCORE.
// Define MATCH_SCORE_SEG_EN to build the 7-seg decoder; otherwise hex outputs are blanked.
module match_score_fsm #(
  parameter int unsigned SCORE_W   = 3,
  parameter int unsigned WIN_SCORE = 7,
  parameter int unsigned PAUSE_CYC = 4
) (
  input logic          clk,
  input logic          reset,
  match_score_if.slave bus
);

  localparam int unsigned        CNT_W      = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
  localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_CYC - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [1:0] {StPlay, StPoint, StOver} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               round_rst_q, round_rst_d;
  logic               match_over_q, match_over_d;
  logic [1:0]         winner_q, winner_d;
  logic               l_hit, r_hit;

  // Simultaneous presses cancel each other out.
  assign l_hit = bus.l_press & ~bus.r_press & bus.l_edge;
  assign r_hit = bus.r_press & ~bus.l_press & bus.r_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StPlay;
      cnt_q        <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      round_rst_q  <= 1'b0;
      match_over_q <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      round_rst_q  <= round_rst_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    round_rst_d  = round_rst_q;
    match_over_d = match_over_q;
    winner_d     = winner_q;

    case (state_q)
      StPlay: begin
        round_rst_d = 1'b0;
        if (l_hit || r_hit) begin
          if (l_hit) score_l_d = score_l_q + SCORE_ONE;
          else       score_r_d = score_r_q + SCORE_ONE;
          round_rst_d = 1'b1;
          if ((l_hit && score_l_d == WIN_VAL) || (r_hit && score_r_d == WIN_VAL)) begin
            state_d      = StOver;
            match_over_d = 1'b1;
            winner_d     = l_hit ? 2'b01 : 2'b10;
          end else begin
            state_d = StPoint;
            cnt_d   = PAUSE_LOAD;
          end
        end
      end
      StPoint: begin
        if (cnt_q == '0) begin
          state_d     = StPlay;
          round_rst_d = 1'b0;
        end else begin
          cnt_d       = cnt_q - CNT_W'(1);
          round_rst_d = 1'b1;
        end
      end
      StOver: begin
        round_rst_d  = 1'b1;
        match_over_d = 1'b1;
      end
      default: begin
        state_d     = StPlay;
        round_rst_d = 1'b0;
      end
    endcase

    // new_game overrides whatever the current state decided.
    if (bus.new_game) begin
      state_d      = StPoint;
      cnt_d        = PAUSE_LOAD;
      score_l_d    = '0;
      score_r_d    = '0;
      winner_d     = 2'b00;
      match_over_d = 1'b0;
      round_rst_d  = 1'b1;
    end
  end

  assign bus.score_l    = score_l_q;
  assign bus.score_r    = score_r_q;
  assign bus.round_rst  = round_rst_q;
  assign bus.match_over = match_over_q;
  assign bus.winner     = winner_q;

`ifdef MATCH_SCORE_SEG_EN
  // Active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign bus.hex_l = seg7(4'(score_l_q));
  assign bus.hex_r = seg7(4'(score_r_q));
`else
  assign bus.hex_l = 7'h7F;
  assign bus.hex_r = 7'h7F;
`endif

endmodule
